cache_fill_arbiter: RTL
=======================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first; one clock, reset synchronous and active-low:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  I-cache miss request, level, held until i_done
- i_addr  in  16  I-cache miss byte address
- d_req  in  1  D-cache request, level, held until d_done
- d_wr  in  1  D request is a single-word write (else block fill)
- d_addr  in  16  D byte address
- d_wdata  in  16  D write data
- mem_en  out  1  memory access issue
- mem_wr  out  1  memory write qualifier
- mem_addr  out  16  memory word address (byte address, bit0=0)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  read data valid, exactly MEM_LAT cycles after issue
- fill_data  out  16  returned word, shared by both caches
- fill_idx  out  3  word index within block
- i_fill_we  out  1  write fill_data into I-cache line
- d_fill_we  out  1  write fill_data into D-cache line
- i_done  out  1  one-cycle I transaction completion
- d_done  out  1  one-cycle D transaction completion
- busy  out  1  arbiter not in IDLE

Function
REQ-002 SHALL implement FSM states IDLE, FILL, WRITE, RET.
REQ-003 IDLE: no request -> stay; grant -> latch owner, address, wr, wdata; next FILL (read) or WRITE (d_wr=1).
REQ-004 Default arbitration: d_req wins over i_req when both are high in the same cycle.
REQ-005 Block base = latched addr & 16'hFFF0; BLOCK_WORDS=8; word k address = base + 2k; no carry beyond the block (addr 0xFFFE -> reads 0xFFF0..0xFFFE).
REQ-006 FILL: issue one read per cycle, k=0..7, on the 8 cycles after grant (mem_en=1, mem_wr=0); 3-bit issue counter.
REQ-007 Each mem_rvalid: fill_data=mem_rdata, fill_idx=receive count, owner's fill_we=1; the other fill_we stays 0; 3-bit receive counter.
REQ-008 Owner's done SHALL pulse in the same cycle as the 8th fill_we; next state RET. Grant-to-done latency = 8+MEM_LAT cycles (12 at MEM_LAT=4).
REQ-009 WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr & 16'hFFFE, mem_wdata=d_wdata; d_done pulses that cycle; next RET.
REQ-010 RET: one cycle, requests ignored, requester drops req; next IDLE. Minimum back-to-back grant spacing = transaction + 1 cycle.
REQ-011 mem_rvalid outside FILL, or with receive count already 8, SHALL be ignored.
REQ-012 mem_addr, mem_wdata and fill_data SHALL be 0 when their qualifier is low; busy=1 in FILL, WRITE and RET.

Reset
REQ-013 rst_n=0 at a clock edge: state IDLE, counters 0, owner cleared, all outputs 0; an in-progress fill is abandoned without a done pulse.
REQ-014 mem_rvalid returns from reads issued before reset SHALL be ignored (REQ-011).

Configuration
REQ-015 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant goes to the requester not granted last; the last-granted bit resets to I, so D wins the first tie.
REQ-016 Without ARB_ROUND_ROBIN_EN: fixed D priority per REQ-004.

Structure
REQ-017 Shared package cache_arb_pkg SHALL hold the state enum, BLOCK_WORDS=8, MEM_LAT=4 and the owner encoding (OWN_I, OWN_D).
REQ-018 The grant logic SHALL be one sub-module, arb_select (inputs i_req, d_req, last-granted bit; output owner).

Verification
REQ-019 i_req with i_addr=0x1236 -> reads issued to 0x1230..0x123E on cycles 1-8; i_fill_we idx 0..7 on cycles 5-12; i_done at cycle 12.
REQ-020 d_req, d_wr=1, d_addr=0x4002, d_wdata=0xBEEF -> single mem write of 0xBEEF to 0x4002, d_done same cycle, busy low two cycles later.
REQ-021 i_req and d_req (fill) raised in the same cycle -> D fill completes first, I granted after RET; with ARB_ROUND_ROBIN_EN a second tie grants I first.
REQ-022 d_addr=0xFFFE fill -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
REQ-023 rst_n low at cycle 6 of a fill -> outputs 0 next cycle; the 4 late mem_rvalid pulses produce no fill_we or done.
REQ-024 Requests held during RET -> no grant until IDLE; i_fill_we and d_fill_we never high together.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache fill arbiter.
// State enum, owner encoding, block geometry and memory latency.
package cache_arb_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT     = 4;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam logic [15:0] WORD_MASK  = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RET
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  // Word k of a block never carries out of the block.
  function automatic logic [15:0] word_addr(
    input logic [15:0] base,
    input logic [2:0]  k
  );
    return base | {12'd0, k, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_arb_select.sv
// Grant selection between I and D requesters.
// ARB_ROUND_ROBIN_EN: ties go to the side not granted last; else D wins.
module arb_select
  import cache_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last,
  output owner_t owner
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t tie_own;
  assign tie_own = (last == OWN_I) ? OWN_D : OWN_I;
`else
  owner_t tie_own;
  logic   unused_last;
  assign tie_own     = OWN_D;
  assign unused_last = last;
`endif

  always_comb begin
    owner = OWN_I;
    if (i_req && d_req) begin
      owner = tie_own;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses onto one memory port (block fill or word write).
// Tie policy selected by ARB_ROUND_ROBIN_EN inside arb_select.
module cache_fill_arbiter
  import cache_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  state_t state;
  state_t state_nxt;
  txn_t   txn;
  owner_t last;
  owner_t grant_own;

  logic [2:0]         issue_cnt;
  logic               issue_fin;
  logic [2:0]         rcv_cnt;
  logic [MEM_LAT-1:0] inflight;

  logic grant;
  logic issue;
  logic beat;
  logic last_beat;

  arb_select u_sel (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last),
    .owner (grant_own)
  );

  assign grant = i_req | d_req;
  assign issue = (state == FILL) && !issue_fin;

  // Only returns matching one of our own issues are accepted, so
  // reads launched before a reset can never be mistaken for data.
  assign beat      = (state == FILL) && mem_rvalid
                   && inflight[MEM_LAT-1];
  assign last_beat = beat
                   && (rcv_cnt == 3'(BLOCK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant) begin
          if (grant_own == OWN_D && d_wr) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (last_beat) begin
          state_nxt = RET;
        end
      end
      WRITE:   state_nxt = RET;
      RET:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn       <= '0;
      last      <= OWN_I;
      issue_cnt <= '0;
      issue_fin <= 1'b0;
      rcv_cnt   <= '0;
      inflight  <= '0;
    end else begin
      inflight <= {inflight[MEM_LAT-2:0], issue};
      if (state == IDLE && grant) begin
        txn.owner <= grant_own;
        txn.addr  <= (grant_own == OWN_D) ? d_addr : i_addr;
        txn.wdata <= d_wdata;
        last      <= grant_own;
        issue_cnt <= '0;
        issue_fin <= 1'b0;
        rcv_cnt   <= '0;
      end
      if (issue) begin
        issue_cnt <= issue_cnt + 3'd1;
        if (issue_cnt == 3'(BLOCK_WORDS - 1)) begin
          issue_fin <= 1'b1;
        end
      end
      if (beat) begin
        rcv_cnt <= rcv_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_data = '0;
    fill_idx  = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      FILL: begin
        if (issue) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(txn.addr & BLOCK_MASK,
                               issue_cnt);
        end
        if (beat) begin
          fill_data = mem_rdata;
          fill_idx  = rcv_cnt;
          i_fill_we = (txn.owner == OWN_I);
          d_fill_we = (txn.owner == OWN_D);
          i_done    = last_beat && (txn.owner == OWN_I);
          d_done    = last_beat && (txn.owner == OWN_D);
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = txn.addr & WORD_MASK;
        mem_wdata = txn.wdata;
        d_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
